counter_seq_checker: RTL and testbench

- Downstream consumer of the 16-bit free-running counter stage.
- Samples the counter value on each valid cycle and checks that it advances by exactly STEP modulo 2^WIDTH.
- Tracks lock status, counts sequence errors (saturating) and wrap-around events, and exposes the next expected value.
- Used as an on-chip self-check for counter/register pipelines.

---
 rtl/counter_seq_checker.sv | 161 ++++++++++++++++
 tb/tb_counter_seq_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_checker
// Description : Consumes the value of an upstream free-running counter and
//               checks that each valid sample advances by exactly STEP modulo
//               2^WIDTH. It locks after SYNC_LEN consecutive correct
//               increments, reports sequence errors while locked (saturating
//               counter) and counts wrap-around events.
// Ports       : CLK         - clock, rising edge
//               ASYNCRESETN - asynchronous active-low reset
//               I           - sampled counter value
//               I_valid     - I holds a sample this cycle
//               clear       - synchronous clear of err_count / wrap_count
//               locked      - checker is locked to the sequence
//               err         - one-cycle pulse, mismatch seen while locked
//               err_count   - saturating error count
//               wrap        - one-cycle pulse, locked sequence wrapped
//               wrap_count  - wrap events, modulo 2^16
//               expected    - next expected value (prev + STEP)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_checker #(
  parameter int WIDTH     = 16,
  parameter int STEP      = 1,
  parameter int SYNC_LEN  = 4,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_valid,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 wrap,
  output logic [15:0]          wrap_count,
  output logic [WIDTH-1:0]     expected
);

  // match_cnt only ever holds 0..SYNC_LEN-1: reaching SYNC_LEN locks and clears it.
  localparam int MCW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [MCW-1:0]   MATCH_TOP = MCW'(SYNC_LEN - 1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state_q,      state_d;
  logic [WIDTH-1:0]       prev_q,       prev_d;
  logic [MCW-1:0]         match_cnt_q,  match_cnt_d;
  logic                   locked_q,     locked_d;
  logic                   err_q,        err_d;
  logic                   wrap_q,       wrap_d;
  logic [ERR_WIDTH-1:0]   err_count_q,  err_count_d;
  logic [15:0]            wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0]       expected_q,   expected_d;

  logic                   w_match;

  // expected_q is always prev_q + STEP, so it is the comparison reference.
  assign w_match = (I == expected_q);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    match_cnt_d  = match_cnt_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;

    if (I_valid) begin
      // Every sample becomes the new reference so the checker re-synchronises.
      prev_d = I;
      case (state_q)
        ST_EMPTY: begin
          state_d     = ST_SYNC;
          match_cnt_d = '0;
        end
        ST_SYNC: begin
          if (w_match) begin
            if (match_cnt_q == MATCH_TOP) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MCW'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            // A correct step that lands below the previous value is a wrap.
            if (I < prev_q) begin
              wrap_d       = 1'b1;
              wrap_count_d = wrap_count_q + 16'd1;
            end
          end else begin
            err_d       = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_WIDTH'(1);
            end
            state_d     = ST_SYNC;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          match_cnt_d = '0;
        end
      endcase
    end

    // Clear overrides any same-cycle increment; pulses are unaffected.
    if (clear) begin
      err_count_d  = '0;
      wrap_count_d = '0;
    end

    locked_d   = (state_d == ST_LOCKED);
    expected_d = prev_d + STEP_W;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q      <= ST_EMPTY;
      prev_q       <= '0;
      match_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      expected_q   <= STEP_W;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_cnt_q  <= match_cnt_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      expected_q   <= expected_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign expected   = expected_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_checker
// Description : Self-checking bench for counter_seq_checker. Directed
//               scenarios followed by a randomized phase, all compared
//               against a behavioural model of the sequence rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_checker;

  localparam int WIDTH     = 16;
  localparam int STEP      = 1;
  localparam int SYNC_LEN  = 4;
  localparam int ERR_WIDTH = 8;
  localparam int MODV      = 1 << WIDTH;
  localparam int ERR_MAX   = (1 << ERR_WIDTH) - 1;

  logic                 CLK;
  logic                 ASYNCRESETN;
  logic [WIDTH-1:0]     I;
  logic                 I_valid;
  logic                 clear;
  logic                 locked;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;
  logic                 wrap;
  logic [15:0]          wrap_count;
  logic [WIDTH-1:0]     expected;

  counter_seq_checker #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .SYNC_LEN (SYNC_LEN),
    .ERR_WIDTH(ERR_WIDTH)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .I          (I),
    .I_valid    (I_valid),
    .clear      (clear),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .wrap       (wrap),
    .wrap_count (wrap_count),
    .expected   (expected)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: "have we seen a sample", the last sample, the length
  // of the current run of correct steps and whether we are locked.
  bit m_have;
  int m_prev;
  int m_run;
  bit m_locked;
  bit m_err;
  bit m_wrap;
  int m_errc;
  int m_wrapc;

  function automatic int m_exp();
    return (m_prev + STEP) % MODV;
  endfunction

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_run = 0; m_locked = 0;
    m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic model_sample(input bit v, input int val, input bit clr);
    m_err  = 0;
    m_wrap = 0;
    if (v) begin
      if (!m_have) begin
        m_have = 1;
        m_run  = 0;
      end else if (m_locked) begin
        if (val == m_exp()) begin
          if (val < m_prev) begin
            m_wrap  = 1;
            m_wrapc = (m_wrapc + 1) % 65536;
          end
        end else begin
          m_err    = 1;
          m_errc   = (m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX;
          m_locked = 0;
          m_run    = 0;
        end
      end else begin
        if (val == m_exp()) begin
          m_run = m_run + 1;
          if (m_run >= SYNC_LEN) begin
            m_locked = 1;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_prev = val;
    end
    if (clr) begin
      m_errc  = 0;
      m_wrapc = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("locked",     {31'd0, locked},          {31'd0, m_locked});
    chk("err",        {31'd0, err},             {31'd0, m_err});
    chk("wrap",       {31'd0, wrap},            {31'd0, m_wrap});
    chk("err_count",  {24'd0, err_count},       32'(m_errc));
    chk("wrap_count", {16'd0, wrap_count},      32'(m_wrapc));
    chk("expected",   {16'd0, expected},        32'(m_exp()));
  endtask

  // One clock of stimulus: drive on the falling edge, update the model on
  // the rising edge, compare shortly after it.
  task automatic step(input bit v, input int val, input bit clr);
    @(negedge CLK);
    I_valid = v;
    I       = WIDTH'(val);
    clear   = clr;
    @(posedge CLK);
    model_sample(v, val, clr);
    #1;
    check_all();
  endtask

  task automatic feed_run(input int first, input int count);
    for (int k = 0; k < count; k++) step(1'b1, (first + k * STEP) % MODV, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    ASYNCRESETN = 1'b0;
    I_valid     = 1'b0;
    I           = '0;
    clear       = 1'b0;
    #12;
    // Reset state.
    check_all();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Lock-up from 0..4.
    feed_run(0, 4);
    chk("pre_lock", {31'd0, locked}, 32'd0);
    step(1'b1, 4, 1'b0);
    chk("lock_after_4", {31'd0, locked}, 32'd1);
    chk("exp_after_4", {16'd0, expected}, 32'd5);

    // Error while locked at 0x0010.
    feed_run(5, 12);
    step(1'b1, 16'h0012, 1'b0);
    chk("err_pulse", {31'd0, err}, 32'd1);
    chk("err_cnt_1", {24'd0, err_count}, 32'd1);
    chk("unlock_on_err", {31'd0, locked}, 32'd0);
    chk("exp_0013", {16'd0, expected}, 32'h13);
    feed_run(16'h0013, 4);
    chk("relock_0016", {31'd0, locked}, 32'd1);

    // Wrap-around while locked (mismatch on 0xFFFA re-syncs first).
    feed_run(16'hFFFA, 5);
    step(1'b1, 16'hFFFF, 1'b0);
    chk("no_wrap_ffff", {31'd0, wrap}, 32'd0);
    step(1'b1, 16'h0000, 1'b0);
    chk("wrap_pulse", {31'd0, wrap}, 32'd1);
    chk("wrap_cnt_1", {16'd0, wrap_count}, 32'd1);
    chk("wrap_locked", {31'd0, locked}, 32'd1);

    // Idle cycles between samples leave everything untouched.
    feed_run(1, 5);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h1234, 1'b0);
    step(1'b1, 6, 1'b0);
    chk("idle_no_err", {31'd0, err}, 32'd0);
    chk("idle_locked", {31'd0, locked}, 32'd1);

    // Drive err_count to saturation: each round is one bad sample + relock.
    while (m_errc < ERR_MAX - 1) begin
      step(1'b1, m_exp() ^ 16'h8000, 1'b0);
      feed_run(m_prev + STEP, SYNC_LEN);
    end
    chk("err_cnt_fe", {24'd0, err_count}, 32'hFE);
    step(1'b1, m_exp() ^ 16'h8000, 1'b0);
    chk("err_cnt_ff", {24'd0, err_count}, 32'hFF);
    feed_run(m_prev + STEP, SYNC_LEN);
    step(1'b1, m_exp() ^ 16'h8000, 1'b0);
    chk("err_cnt_sat", {24'd0, err_count}, 32'hFF);
    feed_run(m_prev + STEP, SYNC_LEN);
    step(1'b1, m_exp() ^ 16'h8000, 1'b1);
    chk("clr_err_pulse", {31'd0, err}, 32'd1);
    chk("clr_wins", {24'd0, err_count}, 32'd0);

    // Asynchronous reset while locked at 0x0100.
    feed_run(16'h00FC, 5);
    chk("locked_0100", {31'd0, locked}, 32'd1);
    #2;
    ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_expected", {16'd0, expected}, 32'(STEP));
    check_all();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    step(1'b1, 16'h0200, 1'b0);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    chk("post_rst_exp", {16'd0, expected}, 32'h201);

    // Randomized phase: mostly correct steps with glitches, gaps and clears.
    for (int n = 0; n < 1500; n++) begin
      int  sel;
      int  val;
      bit  v;
      bit  c;
      sel = int'($urandom_range(0, 99));
      if (sel < 75)      val = m_exp();
      else if (sel < 85) val = (m_exp() + int'($urandom_range(1, 3))) % MODV;
      else               val = int'($urandom_range(0, MODV - 1));
      if ($urandom_range(0, 49) == 0) val = 16'hFFFF;
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 39) == 0);
      step(v, val, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
